// File: rtl/intr_pkg.sv
// intr_pkg: shared interrupt constants, dispatcher FSM states and one-hot/index helpers
package intr_pkg;
    localparam int NUM_INTR = 8;
    localparam int IDX_W = 3;
    typedef enum logic [1:0] {IDLE, ACK, JUMP, RET} state_t;
    function automatic logic [IDX_W-1:0] oh2idx(input logic [NUM_INTR-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < NUM_INTR; i++)
            if (oh[i]) oh2idx = oh2idx | IDX_W'(i);
    endfunction
    function automatic logic [NUM_INTR-1:0] idx2oh(input logic [IDX_W-1:0] idx);
        return NUM_INTR'(1) << idx;
    endfunction
endpackage

// File: rtl/ret_stack.sv
// ret_stack: synchronous LIFO, entry 0 is the top (ports clk, reset active-low sync, push, pop, din, top, empty, full)
module ret_stack #(
    parameter int W = 13,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [CW-1:0] cnt;
    assign top = mem[0];
    assign empty = cnt == '0;
    assign full = cnt == CW'(DEPTH);
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (push) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
            cnt <= cnt + 1'b1;
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/intr_dispatcher.sv
// intr_dispatcher: redirects the CPU to interrupt vectors and back on reti (in: clk, reset active-low sync, min_bit_s, intr_enable, instr_boundary, reti, pc; out: call_intr, s_return_intr, take_intr, vector_addr, take_ret, ret_addr, stall, spurious_reti; INTR_NESTING_EN enables 8-deep preemption)
module intr_dispatcher
    import intr_pkg::*;
#(
    parameter int PC_W = 10,
    parameter logic [PC_W-1:0] VEC_BASE = 10'h3C0,
    parameter int VEC_STRIDE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_INTR-1:0] min_bit_s,
    input  logic                intr_enable,
    input  logic                instr_boundary,
    input  logic                reti,
    input  logic [PC_W-1:0]     pc,
    output logic [NUM_INTR-1:0] call_intr,
    output logic [NUM_INTR-1:0] s_return_intr,
    output logic                take_intr,
    output logic [PC_W-1:0]     vector_addr,
    output logic                take_ret,
    output logic [PC_W-1:0]     ret_addr,
    output logic                stall,
    output logic                spurious_reti
);
`ifdef INTR_NESTING_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif
    state_t state;
    logic [NUM_INTR-1:0] req;
    logic [PC_W+IDX_W-1:0] top;
    logic empty, full, eligible;
    logic [IDX_W-1:0] idx, top_idx, req_idx;
    logic [IDX_W:0] cur;
    assign idx = oh2idx(min_bit_s);
    assign req_idx = oh2idx(req);
    assign top_idx = top[IDX_W-1:0];
    // an empty stack behaves as an in-service level below every line
    assign cur = empty ? (IDX_W+1)'(NUM_INTR) : {1'b0, top_idx};
`ifdef INTR_NESTING_EN
    assign eligible = |min_bit_s && {1'b0, idx} < cur && intr_enable && instr_boundary;
`else
    assign eligible = |min_bit_s && empty && intr_enable && instr_boundary;
`endif
    ret_stack #(.W(PC_W + IDX_W), .DEPTH(DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (state == ACK),
        .pop   (state == RET),
        .din   ({pc, req_idx}),
        .top   (top),
        .empty (empty),
        .full  (full)
    );
    always_ff @(posedge clk)
        if (reset) assert (!(state == ACK && full));
    // outputs are registered on entry to the state in which they are defined
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            req <= '0;
            call_intr <= '0;
            s_return_intr <= '0;
            take_intr <= 1'b0;
            vector_addr <= '0;
            take_ret <= 1'b0;
            ret_addr <= '0;
            stall <= 1'b0;
            spurious_reti <= 1'b0;
        end else begin
            call_intr <= '0;
            s_return_intr <= '0;
            take_intr <= 1'b0;
            vector_addr <= '0;
            take_ret <= 1'b0;
            ret_addr <= '0;
            stall <= 1'b0;
            case (state)
                IDLE:
                    if (reti && !empty) begin
                        state <= RET;
                        s_return_intr <= idx2oh(top_idx);
                        ret_addr <= top[PC_W+IDX_W-1:IDX_W];
                        take_ret <= 1'b1;
                        stall <= 1'b1;
                    end else if (reti) begin
                        spurious_reti <= 1'b1;
                    end else if (eligible) begin
                        state <= ACK;
                        req <= min_bit_s;
                        call_intr <= min_bit_s;
                        stall <= 1'b1;
                    end
                ACK: begin
                    state <= JUMP;
                    take_intr <= 1'b1;
                    vector_addr <= VEC_BASE + PC_W'(VEC_STRIDE * int'(req_idx));
                    stall <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intr_dispatcher.sv
// tb_intr_dispatcher: directed self-checking bench for intr_dispatcher
module tb_intr_dispatcher;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] min_bit_s;
    logic intr_enable, instr_boundary, reti;
    logic [9:0] pc;
    logic [7:0] call_intr, s_return_intr;
    logic take_intr, take_ret, stall, spurious_reti;
    logic [9:0] vector_addr, ret_addr;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    intr_dispatcher dut (
        .clk            (clk),
        .reset          (reset),
        .min_bit_s      (min_bit_s),
        .intr_enable    (intr_enable),
        .instr_boundary (instr_boundary),
        .reti           (reti),
        .pc             (pc),
        .call_intr      (call_intr),
        .s_return_intr  (s_return_intr),
        .take_intr      (take_intr),
        .vector_addr    (vector_addr),
        .take_ret       (take_ret),
        .ret_addr       (ret_addr),
        .stall          (stall),
        .spurious_reti  (spurious_reti)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, ".call"}, 32'(call_intr), 0);
        chk({tag, ".sret"}, 32'(s_return_intr), 0);
        chk({tag, ".take_intr"}, 32'(take_intr), 0);
        chk({tag, ".take_ret"}, 32'(take_ret), 0);
        chk({tag, ".stall"}, 32'(stall), 0);
        chk({tag, ".vector"}, 32'(vector_addr), 0);
        chk({tag, ".ret_addr"}, 32'(ret_addr), 0);
    endtask
    initial begin
        reset = 1'b0; min_bit_s = 8'h00; intr_enable = 1'b0; instr_boundary = 1'b0;
        reti = 1'b0; pc = 10'h000;
        step(); step();
        chk_idle("rst");
        chk("rst.spur", 32'(spurious_reti), 0);
        reset = 1'b1; intr_enable = 1'b1; instr_boundary = 1'b1;
        step();
        // dispatch line 2
        min_bit_s = 8'h04; pc = 10'h012;
        step();
        chk("d2.call", 32'(call_intr), 'h04);
        chk("d2.stall1", 32'(stall), 1);
        chk("d2.ti_early", 32'(take_intr), 0);
        step();
        chk("d2.take_intr", 32'(take_intr), 1);
        chk("d2.vector", 32'(vector_addr), 'h3C8);
        chk("d2.call_off", 32'(call_intr), 0);
        chk("d2.stall2", 32'(stall), 1);
        step();
        chk("d2.stall_off", 32'(stall), 0);
        chk("d2.ti_off", 32'(take_intr), 0);
        step();
        chk("d2.no_redispatch", 32'(call_intr), 0);
        // line 0 requested while line 2 in service
        min_bit_s = 8'h01; pc = 10'h034;
`ifdef INTR_NESTING_EN
        step();
        chk("pre.call", 32'(call_intr), 'h01);
        step();
        chk("pre.vector", 32'(vector_addr), 'h3C0);
        step();
        reti = 1'b1;
        step();
        chk("pre.sret0", 32'(s_return_intr), 'h01);
        chk("pre.ret0", 32'(ret_addr), 'h034);
        chk("pre.take_ret", 32'(take_ret), 1);
        reti = 1'b0; min_bit_s = 8'h04;
        step();
        chk("pre.gap", 32'(take_ret), 0);
        reti = 1'b1;
        step();
        chk("pre.sret2", 32'(s_return_intr), 'h04);
        chk("pre.ret2", 32'(ret_addr), 'h012);
        reti = 1'b0; min_bit_s = 8'h00;
        step();
`else
        step();
        chk("hold.call_a", 32'(call_intr), 0);
        step();
        chk("hold.call_b", 32'(call_intr), 0);
        chk("hold.stall", 32'(stall), 0);
        reti = 1'b1;
        step();
        chk("hold.sret2", 32'(s_return_intr), 'h04);
        chk("hold.ret2", 32'(ret_addr), 'h012);
        chk("hold.take_ret", 32'(take_ret), 1);
        chk("hold.call_c", 32'(call_intr), 0);
        reti = 1'b0;
        step();
        chk("hold.call_d", 32'(call_intr), 0);
        chk("hold.take_ret_off", 32'(take_ret), 0);
        step();
        chk("hold.call0", 32'(call_intr), 'h01);
        step();
        chk("hold.vector0", 32'(vector_addr), 'h3C0);
        step();
        reti = 1'b1;
        step();
        chk("hold.sret0", 32'(s_return_intr), 'h01);
        chk("hold.ret0", 32'(ret_addr), 'h034);
        reti = 1'b0; min_bit_s = 8'h00;
        step();
`endif
        // line 5 dispatch
        min_bit_s = 8'h20; pc = 10'h155;
        step();
        chk("d5.call", 32'(call_intr), 'h20);
        step();
        chk("d5.vector", 32'(vector_addr), 'h3D4);
        step();
        // reti and eligible request in the same cycle: return first
        reti = 1'b1; min_bit_s = 8'h01; pc = 10'h2A0;
        step();
        chk("rw.take_ret", 32'(take_ret), 1);
        chk("rw.sret", 32'(s_return_intr), 'h20);
        chk("rw.ret", 32'(ret_addr), 'h155);
        chk("rw.call_a", 32'(call_intr), 0);
        reti = 1'b0;
        step();
        chk("rw.call_b", 32'(call_intr), 0);
        step();
        chk("rw.call0", 32'(call_intr), 'h01);
        step();
        chk("rw.vector0", 32'(vector_addr), 'h3C0);
        step();
        reti = 1'b1;
        step();
        chk("rw.sret0", 32'(s_return_intr), 'h01);
        chk("rw.ret0", 32'(ret_addr), 'h2A0);
        reti = 1'b0; min_bit_s = 8'h00;
        step();
        // spurious reti
        chk("sp.before", 32'(spurious_reti), 0);
        reti = 1'b1;
        step();
        chk("sp.set", 32'(spurious_reti), 1);
        chk("sp.take_ret", 32'(take_ret), 0);
        chk("sp.sret", 32'(s_return_intr), 0);
        chk("sp.stall", 32'(stall), 0);
        reti = 1'b0;
        step(); step();
        chk("sp.sticky", 32'(spurious_reti), 1);
        // gating by enable and boundary
        min_bit_s = 8'h80; intr_enable = 1'b0;
        step(); step();
        chk("gate.en_call", 32'(call_intr), 0);
        chk("gate.en_stall", 32'(stall), 0);
        intr_enable = 1'b1; instr_boundary = 1'b0;
        step();
        chk("gate.ib_call", 32'(call_intr), 0);
        instr_boundary = 1'b1;
        step();
        chk("gate.call7", 32'(call_intr), 'h80);
        // reset during ACK
        reset = 1'b0;
        step();
        chk_idle("racK");
        chk("rack.spur", 32'(spurious_reti), 0);
        reset = 1'b1; min_bit_s = 8'h00;
        step();
        chk("rack.no_jump", 32'(take_intr), 0);
        reti = 1'b1;
        step();
        chk("rack.empty_spur", 32'(spurious_reti), 1);
        chk("rack.empty_ret", 32'(take_ret), 0);
        reti = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
